// File: rtl/matmul_pkg.sv
// Shared types, pipeline constants and arithmetic helpers for the matrix-multiply engine.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // issue -> read data -> product -> accumulate
    localparam int PIPE_LAT = 3;

    // Wide enough to hold any accumulator after sign/zero extension.
    localparam int SAT_W = 128;

    typedef struct packed {
        logic hi;
        logic lo;
    } clip_t;

    function automatic bit acc_width_ok(input int n, input int data_w, input int acc_w);
        return acc_w >= 2 * data_w + $clog2(n);
    endfunction

    function automatic clip_t clamp_signed(input logic signed [SAT_W-1:0] v, input int out_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        clip_t r;
        hi   = (SAT_W'(1) << (out_w - 1)) - SAT_W'(1);
        lo   = ~hi;
        r.hi = v > hi;
        r.lo = v < lo;
        return r;
    endfunction

    function automatic clip_t clamp_unsigned(input logic [SAT_W-1:0] v, input int out_w);
        logic [SAT_W-1:0] hi;
        clip_t r;
        hi   = (SAT_W'(1) << out_w) - SAT_W'(1);
        r.hi = v > hi;
        r.lo = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/matmul_engine_mac_pipe.sv
// Two-stage MAC: registered full-width product, then load (first term) or accumulate.
module mac_pipe #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);
    localparam int PROD_W = 2 * DATA_W;

    logic              a_sx, b_sx, p_sx;
    logic [PROD_W-1:0] a_ext, b_ext;
    logic [PROD_W-1:0] prod_reg;
    logic              prod_valid_reg, prod_first_reg;
    logic [ACC_W-1:0]  prod_acc;
    logic [ACC_W-1:0]  acc_reg;

    // Extending both operands to the product width gives the correct signed low half.
    assign a_sx     = (SIGNED != 0) && a[DATA_W-1];
    assign b_sx     = (SIGNED != 0) && b[DATA_W-1];
    assign a_ext    = {{DATA_W{a_sx}}, a};
    assign b_ext    = {{DATA_W{b_sx}}, b};
    assign p_sx     = (SIGNED != 0) && prod_reg[PROD_W-1];
    assign prod_acc = {{(ACC_W - PROD_W){p_sx}}, prod_reg};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_reg       <= '0;
            prod_valid_reg <= 1'b0;
            prod_first_reg <= 1'b0;
            acc_reg        <= '0;
        end else begin
            prod_reg       <= a_ext * b_ext;
            prod_valid_reg <= in_valid;
            prod_first_reg <= in_first;
            if (prod_valid_reg) begin
                acc_reg <= prod_first_reg ? prod_acc : acc_reg + prod_acc;
            end
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/matmul_engine.sv
// N x N matrix multiply R = A x B: one read pair per cycle, one R write per N cycles.
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32,
    parameter int SIGNED = 1,
    parameter int ADDR_W = $clog2(N * N)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              sat_en,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_rdata,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_rdata,
    output logic              r_we,
    output logic [ADDR_W-1:0] r_addr,
    output logic [OUT_W-1:0]  r_wdata
);
    localparam int              IDX_W      = $clog2(N);
    localparam logic [IDX_W-1:0] LAST      = IDX_W'(N - 1);
    localparam int              DRAIN_W    = $clog2(PIPE_LAT);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

    generate
        if (!acc_width_ok(N, DATA_W, ACC_W)) begin : g_bad_acc_w
            $error("ACC_W too narrow for N and DATA_W");
        end
        if (OUT_W > ACC_W) begin : g_bad_out_w
            $error("OUT_W must not exceed ACC_W");
        end
    endgenerate

    state_t             state_reg;
    logic [IDX_W-1:0]   i_reg, j_reg, k_reg;
    logic [DRAIN_W-1:0] drain_reg;
    logic               busy_reg, done_reg, ovf_reg, sat_en_reg;
    logic               issue, issue_last;
    logic [ADDR_W-1:0]  issue_r_addr;

    // Per-element tags ride alongside the MAC pipeline; only the k=N-1 term carries an address.
    logic               vld0_reg, fst0_reg;
    logic               lst_reg  [PIPE_LAT];
    logic [ADDR_W-1:0]  radr_reg [PIPE_LAT];

    logic [ACC_W-1:0]   acc;
    logic [SAT_W-1:0]   acc_wide;
    clip_t              clip;
    logic               clipped;
    logic [OUT_W-1:0]   conv;

    assign issue        = (state_reg == RUN);
    assign issue_last   = issue && (k_reg == LAST);
    assign a_rd_en      = issue;
    assign b_rd_en      = issue;
    assign a_addr       = ADDR_W'(i_reg) * ADDR_W'(N) + ADDR_W'(k_reg);
    assign b_addr       = ADDR_W'(k_reg) * ADDR_W'(N) + ADDR_W'(j_reg);
    assign issue_r_addr = ADDR_W'(i_reg) * ADDR_W'(N) + ADDR_W'(j_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld0_reg    <= 1'b0;
            fst0_reg    <= 1'b0;
            lst_reg[0]  <= 1'b0;
            radr_reg[0] <= '0;
        end else begin
            vld0_reg    <= issue;
            fst0_reg    <= issue && (k_reg == '0);
            lst_reg[0]  <= issue_last;
            radr_reg[0] <= issue_last ? issue_r_addr : '0;
        end
    end

    generate
        for (genvar gi = 1; gi < PIPE_LAT; gi++) begin : g_tag
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    lst_reg[gi]  <= 1'b0;
                    radr_reg[gi] <= '0;
                end else begin
                    lst_reg[gi]  <= lst_reg[gi-1];
                    radr_reg[gi] <= radr_reg[gi-1];
                end
            end
        end
    endgenerate

    mac_pipe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (vld0_reg),
        .in_first (fst0_reg),
        .a        (a_rdata),
        .b        (b_rdata),
        .acc      (acc)
    );

    always_comb begin
        acc_wide = {{(SAT_W - ACC_W){(SIGNED != 0) && acc[ACC_W-1]}}, acc};
        clip     = (SIGNED != 0) ? clamp_signed(acc_wide, OUT_W) : clamp_unsigned(acc_wide, OUT_W);
        clipped  = sat_en_reg && (clip.hi || clip.lo);
        conv     = acc[OUT_W-1:0];
        if (sat_en_reg && clip.hi) begin
            conv = (SIGNED != 0) ? {1'b0, {(OUT_W-1){1'b1}}} : '1;
        end else if (sat_en_reg && clip.lo) begin
            conv = (SIGNED != 0) ? {1'b1, {(OUT_W-1){1'b0}}} : '0;
        end
    end

    assign r_we    = lst_reg[PIPE_LAT-1];
    assign r_addr  = radr_reg[PIPE_LAT-1];
    assign r_wdata = r_we ? conv : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            i_reg      <= '0;
            j_reg      <= '0;
            k_reg      <= '0;
            drain_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            sat_en_reg <= 1'b0;
        end else begin
            if (r_we && clipped) begin
                ovf_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg  <= RUN;
                        busy_reg   <= 1'b1;
                        sat_en_reg <= sat_en;
                        ovf_reg    <= 1'b0;
                        i_reg      <= '0;
                        j_reg      <= '0;
                        k_reg      <= '0;
                    end
                end
                RUN: begin
                    k_reg <= k_reg + 1'b1;
                    if (k_reg == LAST) begin
                        k_reg <= '0;
                        j_reg <= j_reg + 1'b1;
                        if (j_reg == LAST) begin
                            j_reg <= '0;
                            i_reg <= i_reg + 1'b1;
                            if (i_reg == LAST) begin
                                i_reg     <= '0;
                                drain_reg <= '0;
                                state_reg <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    drain_reg <= drain_reg + 1'b1;
                    if (drain_reg == DRAIN_LAST) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign ovf  = ovf_reg;

endmodule
